// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external combinational ALU between two requesters.
module alu_arbiter #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        op0,
  input  logic [3:0]        op1,
  input  logic [WORD_W-1:0] a0,
  input  logic [WORD_W-1:0] b0,
  input  logic [WORD_W-1:0] a1,
  input  logic [WORD_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [WORD_W-1:0] res_o,
  output logic              res_n,
  output logic              res_z,
  output logic              res_v,
  output logic [3:0]        alu_op,
  output logic [WORD_W-1:0] alu_a,
  output logic [WORD_W-1:0] alu_b,
  input  logic [WORD_W-1:0] alu_o,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q;
  logic owner_q, last_q, done0_q, done1_q;
  logic res_n_q, res_z_q, res_v_q;
  logic [3:0] op_q;
  logic [WORD_W-1:0] a_q, b_q, res_q;
  logic take, win1;
  // Grant is same-cycle with the IDLE request, so it is decoded, and masked while in reset.
  assign take = nRST && state_q == IDLE && (req0 || req1);
  assign win1 = req1 && (!req0 || !last_q);
  assign gnt0 = take && !win1;
  assign gnt1 = take && win1;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign res_o = res_q;
  assign res_n = res_n_q;
  assign res_z = res_z_q;
  assign res_v = res_v_q;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      res_n_q <= 1'b0;
      res_z_q <= 1'b0;
      res_v_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          op_q <= win1 ? op1 : op0;
          a_q <= win1 ? a1 : a0;
          b_q <= win1 ? b1 : b0;
          owner_q <= win1;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q <= alu_o;
          res_n_q <= alu_n;
          res_z_q <= alu_z;
          res_v_q <= alu_v;
          done0_q <= !owner_q;
          done1_q <= owner_q;
          state_q <= RESP;
        end
        RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          last_q <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-scheduling model.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  logic CLK = 1'b0, nRST = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [3:0] op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, done0, done1, res_n, res_z, res_v, alu_n, alu_z, alu_v;
  logic [W-1:0] res_o, alu_a, alu_b, alu_o;
  logic [3:0] alu_op;
  int checks = 0, failures = 0;

  alu_arbiter #(.WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .res_o(res_o), .res_n(res_n), .res_z(res_z),
    .res_v(res_v), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v)
  );

  always #5 CLK = ~CLK;

  // Shared ALU environment: returns {result, n, z, v}.
  function automatic logic [W+2:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic v;
    v = 1'b0;
    r = 32'h0BADC0DE;
    case (op)
      ADD: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      SUB: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      AND_: r = a & b;
      OR_: r = a | b;
      XOR_: r = a ^ b;
      default: ;
    endcase
    return {r, r[W-1], r == '0, v};
  endfunction

  assign {alu_o, alu_n, alu_z, alu_v} = alu_f(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: a grant books the ALU for three cycles; done and result appear two cycles after grant.
  int cyc = 0, busy_until = 0, done_at = -1, lat_at = -1;
  logic last = 1'b1, done_own = 1'b0, w;
  logic eg0, eg1, ed0, ed1;
  logic [W+2:0] pend = '0, exp_res = '0;
  logic [3:0] lat_op = '0, exp_op = '0;
  logic [W-1:0] lat_a = '0, lat_b = '0, exp_a = '0, exp_b = '0;

  always @(negedge CLK) begin
    cyc++;
    eg0 = 1'b0; eg1 = 1'b0; ed0 = 1'b0; ed1 = 1'b0;
    if (!nRST) begin
      busy_until = 0; done_at = -1; lat_at = -1; last = 1'b1;
      exp_res = '0; exp_op = '0; exp_a = '0; exp_b = '0;
    end else begin
      if (cyc == lat_at) begin exp_op = lat_op; exp_a = lat_a; exp_b = lat_b; end
      if (cyc >= busy_until && (req0 || req1)) begin
        w = (req0 && req1) ? ~last : req1;
        eg0 = !w; eg1 = w;
        lat_op = w ? op1 : op0; lat_a = w ? a1 : a0; lat_b = w ? b1 : b0;
        pend = alu_f(lat_op, lat_a, lat_b);
        busy_until = cyc + 3; done_at = cyc + 2; lat_at = cyc + 1;
        done_own = w; last = w;
      end
      if (cyc == done_at) begin ed0 = !done_own; ed1 = done_own; exp_res = pend; end
    end
    check("gnt0", gnt0, eg0);
    check("gnt1", gnt1, eg1);
    check("done0", done0, ed0);
    check("done1", done1, ed1);
    check("res", {res_o, res_n, res_z, res_v}, exp_res);
    check("alu_in", {alu_op, alu_a, alu_b}, {exp_op, exp_a, exp_b});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick(2);
    nRST = 1'b1;
  endtask

  int q[$];
  logic g0, g1;

  initial begin
    #1 nRST = 1'b0;
    @(negedge CLK);
    check("rst_res", {res_o, res_n, res_z, res_v}, 0);
    check("rst_gnt", {gnt0, gnt1, done0, done1}, 0);
    tick(1);
    // single requester ADD
    nRST = 1'b1; req0 = 1; op0 = ADD; a0 = 5; b0 = 7;
    @(negedge CLK); check("t27_gnt0", gnt0, 1);
    tick(1); req0 = 0;
    tick(1); @(negedge CLK);
    check("t27_done0", done0, 1);
    check("t27_res", {res_o, res_z, res_v}, {32'd12, 2'b00});
    tick(1);
    // tie from reset: requester 0 first, then 1
    do_reset();
    req0 = 1; op0 = SUB; a0 = 3; b0 = 3; req1 = 1; op1 = OR_; a1 = 32'hF0; b1 = 32'h0F;
    @(negedge CLK); check("t28_gnt", {gnt0, gnt1}, 2'b10);
    tick(1); req0 = 0;
    tick(1); @(negedge CLK);
    check("t28_done0", {done0, done1}, 2'b10);
    check("t28_res0", {res_o, res_z}, {32'd0, 1'b1});
    tick(1); @(negedge CLK); check("t28_gnt1", {gnt0, gnt1}, 2'b01);
    tick(1); req1 = 0;
    tick(1); @(negedge CLK);
    check("t28_done1", {done0, done1}, 2'b01);
    check("t28_res1", res_o, 32'hFF);
    tick(1);
    // both held for four operations
    req0 = 1; op0 = ADD; a0 = 1; b0 = 2; req1 = 1; op1 = XOR_; a1 = 6; b1 = 3;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (gnt0) q.push_back(0);
      if (gnt1) q.push_back(1);
      tick(1);
    end
    req0 = 0; req1 = 0;
    check("t29_cnt", q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) check("t29_ord", q[i], i % 2);
    // overflow on requester 1; requester 0 arriving in EXEC waits
    req1 = 1; op1 = ADD; a1 = 32'h7FFFFFFF; b1 = 1;
    @(negedge CLK); check("t30_gnt1", gnt1, 1);
    tick(1); req1 = 0; req0 = 1; op0 = AND_; a0 = 32'hFF; b0 = 32'h0F;
    @(negedge CLK); check("t30_exec_nogrant", gnt0, 0);
    tick(1); @(negedge CLK);
    check("t30_resp_nogrant", gnt0, 0);
    check("t30_done1", done1, 1);
    check("t30_res", {res_o, res_n, res_v}, {32'h80000000, 2'b11});
    tick(1); @(negedge CLK); check("t30_gnt0", gnt0, 1);
    tick(1); req0 = 0;
    tick(2);
    // reset during EXEC aborts the operation
    req0 = 1; op0 = ADD; a0 = 2; b0 = 3;
    @(negedge CLK); check("t31_gnt0", gnt0, 1);
    tick(1); nRST = 0;
    @(negedge CLK);
    check("t31_rst_out", {gnt0, gnt1, done0, done1, res_o, res_n, res_z, res_v}, 0);
    check("t31_rst_alu", {alu_op, alu_a, alu_b}, 0);
    tick(2); nRST = 1;
    @(negedge CLK); check("t31_regnt", gnt0, 1);
    tick(1); req0 = 0;
    tick(1); @(negedge CLK);
    check("t31_done0", done0, 1);
    check("t31_res", res_o, 32'd5);
    tick(1);
    // unknown opcode passes through
    req0 = 1; op0 = 4'hF; a0 = 1; b0 = 1;
    @(negedge CLK); check("t32_gnt0", gnt0, 1);
    tick(1); req0 = 0;
    tick(1); @(negedge CLK);
    check("t32_done0", done0, 1);
    check("t32_res", {res_o, res_v}, {32'h0BADC0DE, 1'b0});
    tick(1);
    // randomized traffic with requesters holding until granted
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      g0 = gnt0; g1 = gnt1;
      tick(1);
      if ($urandom_range(0, 199) == 0) nRST = 0;
      else nRST = 1;
      if (!req0 || g0) begin
        req0 = $urandom_range(0, 1);
        op0 = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 4));
        a0 = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
        b0 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      end
      if (!req1 || g1) begin
        req1 = $urandom_range(0, 1);
        op1 = ($urandom_range(0, 9) == 0) ? 4'hE : 4'($urandom_range(0, 4));
        a1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
        b1 = $urandom_range(0, 1) ? $urandom : a1;
      end
    end
    nRST = 1; req0 = 0; req1 = 0;
    tick(4);
    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
